// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass and load-use bubble insertion
module id_ex_stage #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_read_data1,
  input  logic [XLEN-1:0]   id_read_data2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [7:0]        id_ctrl,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_write_data,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              stall_if_id,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_read_data1,
  output logic [XLEN-1:0]   ex_read_data2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [7:0]        ex_ctrl
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rd1_q, rd1_d;
  logic [XLEN-1:0]   rd2_q, rd2_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [7:0]        ctrl_q, ctrl_d;

  logic              wb_fwd_ok;
  logic [XLEN-1:0]   operand1;
  logic [XLEN-1:0]   operand2;
  logic              hazard;

  // The register file writes on the same edge we capture, so forward the WB value here.
  assign wb_fwd_ok = wb_reg_write && (wb_rd != '0);
  assign operand1  = (wb_fwd_ok && (wb_rd == id_rs1)) ? wb_write_data : id_read_data1;
  assign operand2  = (wb_fwd_ok && (wb_rd == id_rs2)) ? wb_write_data : id_read_data2;

  assign hazard = valid_q && ctrl_q[1] && (rd_q != '0) && id_valid &&
                  ((rd_q == id_rs1) || (rd_q == id_rs2));

  assign stall_if_id = reset && (ex_stall || (hazard && !flush));

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (flush || (!ex_stall && hazard)) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!ex_stall) begin
      valid_d = id_valid;
      ctrl_d  = id_valid ? id_ctrl : 8'h00;
      pc_d    = id_pc;
      rd1_d   = operand1;
      rd2_d   = operand2;
      imm_d   = id_imm;
      rs1_d   = id_rs1;
      rs2_d   = id_rs2;
      rd_d    = id_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_read_data1 = rd1_q;
  assign ex_read_data2 = rd2_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_ctrl       = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  localparam logic [7:0] C_ALU  = 8'h11;
  localparam logic [7:0] C_LD   = 8'h0B;
  localparam logic [7:0] C_ADD  = 8'h81;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   id_read_data1, id_read_data2, id_imm;
  logic [7:0]        id_ctrl;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_write_data;
  logic              flush, ex_stall;
  logic              stall_if_id, ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_read_data1, ex_read_data2, ex_imm;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [7:0]        ex_ctrl;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_write_data(wb_write_data),
    .flush(flush), .ex_stall(ex_stall),
    .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [63:0] d1,
                        input logic [63:0] d2, input logic [7:0] ctrl);
    id_valid      = v;
    id_pc         = pc;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_rd         = rd;
    id_read_data1 = d1;
    id_read_data2 = d2;
    id_imm        = pc + 64'h1000;
    id_ctrl       = ctrl;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_write_data = '0;
    set_id(1'b1, 64'h10, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, C_ALU);
    tick(); tick();
    check("rst_valid", {63'd0, ex_valid}, 64'd0);
    check("rst_ctrl", {56'd0, ex_ctrl}, 64'd0);
    check("rst_pc", ex_pc, 64'd0);
    reset = 1'b1;

    // Mid-stream asynchronous reset
    set_id(1'b1, 64'h40, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, C_ALU);
    tick();
    check("pre_rst_pc", ex_pc, 64'h40);
    check("pre_rst_valid", {63'd0, ex_valid}, 64'd1);
    #2 reset = 1'b0; ex_stall = 1'b1;
    #1;
    check("arst_pc", ex_pc, 64'd0);
    check("arst_valid", {63'd0, ex_valid}, 64'd0);
    check("arst_imm", ex_imm, 64'd0);
    check("arst_rd", {59'd0, ex_rd}, 64'd0);
    check("arst_stall", {63'd0, stall_if_id}, 64'd0);
    tick();
    check("arst_hold_pc", ex_pc, 64'd0);
    reset = 1'b1; ex_stall = 1'b0;
    set_id(1'b1, 64'h44, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, C_ALU);
    tick();
    check("rel_pc", ex_pc, 64'h44);
    check("rel_imm", ex_imm, 64'h1044);

    // Capture
    set_id(1'b1, 64'h48, 5'd5, 5'd6, 5'd9, 64'h5, 64'h6, C_ALU);
    tick();
    check("cap_rd1", ex_read_data1, 64'h5);
    check("cap_ctrl", {56'd0, ex_ctrl}, 64'h11);
    check("cap_valid", {63'd0, ex_valid}, 64'd1);
    check("cap_rs1", {59'd0, ex_rs1}, 64'd5);

    // Invalid ID instruction never carries control
    set_id(1'b0, 64'h4C, 5'd5, 5'd6, 5'd9, 64'h5, 64'h6, C_ALU);
    tick();
    check("inv_valid", {63'd0, ex_valid}, 64'd0);
    check("inv_ctrl", {56'd0, ex_ctrl}, 64'd0);

    // WB bypass, then x0 never bypassed
    set_id(1'b1, 64'h50, 5'd3, 5'd4, 5'd9, 64'h3, 64'h4, C_ALU);
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_write_data = 64'h99;
    tick();
    check("byp_rd1", ex_read_data1, 64'h99);
    check("byp_rd2", ex_read_data2, 64'h4);
    set_id(1'b1, 64'h54, 5'd0, 5'd0, 5'd9, 64'h0, 64'h0, C_ALU);
    wb_rd = 5'd0;
    tick();
    check("x0_rd1", ex_read_data1, 64'h0);
    check("x0_rd2", ex_read_data2, 64'h0);
    wb_reg_write = 1'b0;

    // Load-use: ld x7 then add using x7 as rs2
    set_id(1'b1, 64'h60, 5'd2, 5'd0, 5'd7, 64'h2, 64'h0, C_LD);
    tick();
    set_id(1'b1, 64'h64, 5'd1, 5'd7, 5'd8, 64'h1, 64'h7, C_ADD);
    #1 check("lu_stall", {63'd0, stall_if_id}, 64'd1);
    tick();
    check("lu_bub_valid", {63'd0, ex_valid}, 64'd0);
    check("lu_bub_ctrl", {56'd0, ex_ctrl}, 64'd0);
    check("lu_bub_pc_hold", ex_pc, 64'h60);
    check("lu_stall_clr", {63'd0, stall_if_id}, 64'd0);
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_write_data = 64'hDEAD;
    tick();
    check("lu_cap_valid", {63'd0, ex_valid}, 64'd1);
    check("lu_cap_pc", ex_pc, 64'h64);
    check("lu_cap_rd2", ex_read_data2, 64'hDEAD);
    check("lu_cap_ctrl", {56'd0, ex_ctrl}, 64'h81);
    wb_reg_write = 1'b0;

    // Back-to-back loads to x7: one bubble per dependent instruction
    set_id(1'b1, 64'h70, 5'd2, 5'd0, 5'd7, 64'h2, 64'h0, C_LD);
    tick();
    set_id(1'b1, 64'h74, 5'd7, 5'd0, 5'd7, 64'h7, 64'h0, C_LD);
    #1 check("b2b_stall1", {63'd0, stall_if_id}, 64'd1);
    tick();
    check("b2b_bub1", {63'd0, ex_valid}, 64'd0);
    check("b2b_nostall1", {63'd0, stall_if_id}, 64'd0);
    tick();
    check("b2b_cap1_pc", ex_pc, 64'h74);
    set_id(1'b1, 64'h78, 5'd1, 5'd7, 5'd8, 64'h1, 64'h7, C_ADD);
    #1 check("b2b_stall2", {63'd0, stall_if_id}, 64'd1);
    tick();
    check("b2b_bub2", {63'd0, ex_valid}, 64'd0);
    check("b2b_nostall2", {63'd0, stall_if_id}, 64'd0);
    tick();
    check("b2b_cap2_pc", ex_pc, 64'h78);
    check("b2b_cap2_valid", {63'd0, ex_valid}, 64'd1);

    // Flush + hazard + ex_stall together
    set_id(1'b1, 64'h80, 5'd2, 5'd0, 5'd7, 64'h2, 64'h0, C_LD);
    tick();
    set_id(1'b1, 64'h84, 5'd1, 5'd7, 5'd8, 64'h1, 64'h7, C_ADD);
    flush = 1'b1; ex_stall = 1'b1;
    #1 check("fsh_stall", {63'd0, stall_if_id}, 64'd1);
    tick();
    check("fsh_valid", {63'd0, ex_valid}, 64'd0);
    check("fsh_ctrl", {56'd0, ex_ctrl}, 64'd0);
    check("fsh_pc_hold", ex_pc, 64'h80);
    flush = 1'b0; ex_stall = 1'b0;

    // Flush suppresses the hazard stall
    set_id(1'b1, 64'h90, 5'd2, 5'd0, 5'd7, 64'h2, 64'h0, C_LD);
    tick();
    set_id(1'b1, 64'h94, 5'd7, 5'd1, 5'd8, 64'h7, 64'h1, C_ADD);
    flush = 1'b1;
    #1 check("fh_nostall", {63'd0, stall_if_id}, 64'd0);
    tick();
    check("fh_valid", {63'd0, ex_valid}, 64'd0);
    flush = 1'b0;

    // ex_stall held three cycles
    set_id(1'b1, 64'h100, 5'd1, 5'd2, 5'd3, 64'hAA, 64'hBB, C_ALU);
    tick();
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 64'h200 + 64'(4 * i), 5'd4, 5'd5, 5'd6, 64'hB0 + 64'(i), 64'hC0, C_ADD);
      #1 check("stl_stall", {63'd0, stall_if_id}, 64'd1);
      tick();
      check("stl_pc", ex_pc, 64'h100);
      check("stl_rd1", ex_read_data1, 64'hAA);
      check("stl_ctrl", {56'd0, ex_ctrl}, 64'h11);
    end
    ex_stall = 1'b0;
    set_id(1'b1, 64'h300, 5'd4, 5'd5, 5'd6, 64'hCC, 64'hDD, C_ADD);
    tick();
    check("stl_rel_pc", ex_pc, 64'h300);
    check("stl_rel_rd1", ex_read_data1, 64'hCC);
    check("stl_rel_ctrl", {56'd0, ex_ctrl}, 64'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
